// File: rtl/iomem_wb_pkg.sv
// Shared types and constants for the iomem-to-Wishbone bridge.
package iomem_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } iomem_wb_state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;
  localparam int          TMO_W        = 16;

endpackage

// File: rtl/iomem_wb_timeout.sv
// Watchdog for the bridge REQ state: clearable up-counter with a terminal-count flag.
// Only instantiated when IOMEM_WB_TIMEOUT_EN is defined.
module iomem_wb_timeout
  import iomem_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic srst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TMO_W-1:0] TERM = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == TERM);

endmodule

// File: rtl/iomem_wb_bridge.sv
// Registered picosoc iomem -> Wishbone classic bridge, one WB cycle per iomem request.
// Optional ack watchdog enabled by defining IOMEM_WB_TIMEOUT_EN.
module iomem_wb_bridge
  import iomem_wb_pkg::*;
#(
  parameter logic [7:0]  WIN_HI         = 8'h30,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        iomem_valid_i,
  output logic        iomem_ready_o,
  input  logic [3:0]  iomem_wstrb_i,
  input  logic [31:0] iomem_addr_i,
  input  logic [31:0] iomem_wdata_i,
  output logic [31:0] iomem_rdata_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        timeout_o
);

  iomem_wb_state_t state_q, state_d;

  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        valid_ok_q, valid_ok_d;

  logic accept;
  logic tmo_hit;
  logic done;

  assign accept = (state_q == ST_IDLE) && iomem_valid_i && (iomem_addr_i[31:24] == WIN_HI);
  assign done   = (state_q == ST_REQ) && (wbm_ack_i || tmo_hit);

`ifdef IOMEM_WB_TIMEOUT_EN
  logic tmo_expired;
  logic tmo_q, tmo_d;

  iomem_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (wb_clk_i),
    .srst     (wb_rst_i),
    .clr_i    (accept),
    .en_i     (state_q == ST_REQ),
    .expired_o(tmo_expired)
  );

  // An ack on the terminal cycle takes priority over the abort.
  assign tmo_hit = (state_q == ST_REQ) && tmo_expired && !wbm_ack_i;

  always_comb tmo_d = tmo_q | tmo_hit;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdat_q     <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      valid_ok_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      valid_ok_q <= valid_ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ:  if (done)   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_d      = cyc_q;
    we_d       = we_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    valid_ok_d = valid_ok_q;

    if (accept) begin
      addr_d     = iomem_addr_i;
      wdat_d     = iomem_wdata_i;
      we_d       = |iomem_wstrb_i;
      sel_d      = (|iomem_wstrb_i) ? iomem_wstrb_i : 4'b1111;
      cyc_d      = 1'b1;
      valid_ok_d = 1'b1;
    end

    // A master that drops valid mid-cycle loses its ready pulse, but the WB cycle still finishes.
    if (state_q == ST_REQ) begin
      valid_ok_d = valid_ok_q & iomem_valid_i;
      if (done) begin
        cyc_d   = 1'b0;
        ready_d = valid_ok_q & iomem_valid_i;
        rdata_d = wbm_ack_i ? wbm_dat_i : ERR_DATA;
      end
    end
  end

  assign iomem_ready_o = ready_q;
  assign iomem_rdata_o = rdata_q;
  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = cyc_q;
  assign wbm_we_o      = we_q;
  assign wbm_sel_o     = sel_q;
  assign wbm_addr_o    = addr_q;
  assign wbm_dat_o     = wdat_q;

endmodule
